pulse_measure: RTL and testbench

PULSE_MEASURE -- requirements
Module: pulse_measure

---
 rtl/pulse_measure_pkg.sv | 14 +
 rtl/pulse_measure_sync_edge_detect.sv | 33 +++
 rtl/pulse_measure.sv | 114 +++++++++++
 tb/tb_pulse_measure.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_measure_pkg.sv
// Shared definitions for the pulse_measure block: FSM state encoding and
// the default width of the measurement counters.
package pulse_measure_pkg;

    localparam int N_DEFAULT = 17;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_measure_sync_edge_detect.sv
// Brings the asynchronous sig_in into the clk domain and produces one-cycle
// rise/fall strobes. The strobes are registered, so they appear two edges
// after the first synchronizer flop samples the new level.
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic hist_r;

    // Two-flop synchronizer, history flop and registered edge strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
            rise    <= sync2_r & ~hist_r;
            fall    <= ~sync2_r & hist_r;
        end
    end

endmodule

// File: rtl/pulse_measure.sv
// Measures period and high time of a square wave in clk cycles. A period is
// bounded by two rises; the rise that closes one period opens the next, so
// consecutive periods are measured without gaps.
module pulse_measure
    import pulse_measure_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sig_in,
    input  logic         meas_en,
    output logic [N-1:0] period_out,
    output logic [N-1:0] high_out,
    output logic         meas_valid,
    output logic         overflow
);

    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};

    logic         rise_s;
    logic         fall_s;
    state_e       state_r;
    logic [N-1:0] tcnt_r;
    logic [N-1:0] hcnt_r;

    sync_edge_detect u_sync_edge_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // Measurement FSM with period/high counters and registered results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            tcnt_r     <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            period_out <= CNT_ZERO;
            high_out   <= CNT_ZERO;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (!meas_en) begin
            // Disabling discards any open measurement and clears the sticky flag;
            // the last reported results are kept.
            state_r    <= ST_IDLE;
            tcnt_r     <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_WAIT_RISE;
                    tcnt_r  <= CNT_ZERO;
                    hcnt_r  <= CNT_ZERO;
                end
                ST_WAIT_RISE: begin
                    // Only a rise can start a period; a partial first period is skipped.
                    if (rise_s) begin
                        state_r <= ST_HIGH;
                        tcnt_r  <= CNT_ONE;
                        hcnt_r  <= CNT_ONE;
                    end else begin
                        state_r <= ST_WAIT_RISE;
                    end
                end
                ST_HIGH: begin
                    if (tcnt_r == CNT_MAX) begin
                        overflow <= 1'b1;
                        tcnt_r   <= CNT_ZERO;
                        hcnt_r   <= CNT_ZERO;
                        state_r  <= ST_WAIT_RISE;
                    end else if (fall_s) begin
                        tcnt_r  <= tcnt_r + CNT_ONE;
                        state_r <= ST_LOW;
                    end else begin
                        tcnt_r <= tcnt_r + CNT_ONE;
                        hcnt_r <= hcnt_r + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    // A closing rise wins over overflow: the full count is reportable.
                    if (rise_s) begin
                        period_out <= tcnt_r;
                        high_out   <= hcnt_r;
                        meas_valid <= 1'b1;
                        tcnt_r     <= CNT_ONE;
                        hcnt_r     <= CNT_ONE;
                        state_r    <= ST_HIGH;
                    end else if (tcnt_r == CNT_MAX) begin
                        overflow <= 1'b1;
                        tcnt_r   <= CNT_ZERO;
                        hcnt_r   <= CNT_ZERO;
                        state_r  <= ST_WAIT_RISE;
                    end else begin
                        tcnt_r <= tcnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tcnt_r  <= CNT_ZERO;
                    hcnt_r  <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_measure.sv
// Directed testbench for pulse_measure (N=8). A generator drives sig_in as a
// square wave with programmable high/low lengths, or as a forced level.
module tb_pulse_measure;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sig_in;
    logic         meas_en;
    logic [N-1:0] period_out;
    logic [N-1:0] high_out;
    logic         meas_valid;
    logic         overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   vcnt     = 0;

    logic wave_on   = 1'b0;
    logic force_lvl = 1'b0;
    int   hi_len    = 4;
    int   lo_len    = 6;
    int   rem       = 0;

    pulse_measure #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .meas_en    (meas_en),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Cycle counter, one step per rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Count every valid pulse seen.
    always @(negedge clk) if (meas_valid === 1'b1) vcnt++;

    // sig_in generator, updated 2 time units after each rising edge.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!wave_on) begin
                sig_in = force_lvl;
                rem    = 0;
            end else begin
                if (rem == 0) begin
                    if (sig_in) begin
                        sig_in = 1'b0;
                        rem    = lo_len;
                    end else begin
                        sig_in = 1'b1;
                        rem    = hi_len;
                    end
                end
                rem = rem - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a valid pulse, capture results, confirm it lasts one cycle.
    task automatic wait_valid(input string tag, input int budget,
                              output int p, output int h, output int at);
        bit found = 1'b0;
        p  = 0;
        h  = 0;
        at = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                found = 1'b1;
                p     = 32'(period_out);
                h     = 32'(high_out);
                at    = cyc;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            @(negedge clk);
            check({tag, "_1cyc"}, 32'(meas_valid), 32'd0);
        end
    endtask

    int p, h, at, prev, t_en, vc0;

    initial begin
        reset_n = 1'b0;
        meas_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", 32'(period_out), 32'd0);
        check("rst_high",   32'(high_out),   32'd0);
        check("rst_valid",  32'(meas_valid), 32'd0);
        check("rst_ovf",    32'(overflow),   32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // High 4 / low 6: first valid 15 cycles after enabling, then every 10.
        hi_len  = 4;
        lo_len  = 6;
        meas_en = 1'b1;
        wave_on = 1'b1;
        t_en    = cyc;
        wait_valid("w46_first", 40, p, h, at);
        check("w46_latency", 32'(at - t_en), 32'd15);
        check("w46_period",  32'(p), 32'd10);
        check("w46_high",    32'(h), 32'd4);
        prev = at;
        for (int i = 0; i < 3; i++) begin
            wait_valid("w46_next", 20, p, h, at);
            check("w46_period_n", 32'(p), 32'd10);
            check("w46_high_n",   32'(h), 32'd4);
            check("w46_interval", 32'(at - prev), 32'd10);
            prev = at;
        end

        // Switch to high 3 / low 3 mid-run.
        hi_len = 3;
        lo_len = 3;
        for (int i = 0; i < 6; i++) begin
            wait_valid("w33", 20, p, h, at);
            check("w33_no_gap", 32'(at - prev <= 10), 32'd1);
            if (i >= 2) begin
                check("w33_period", 32'(p), 32'd6);
                check("w33_high",   32'(h), 32'd3);
            end
            if (i >= 3) check("w33_interval", 32'(at - prev), 32'd6);
            prev = at;
        end

        // Minimum wave: high 1 / low 1.
        hi_len = 1;
        lo_len = 1;
        for (int i = 0; i < 6; i++) begin
            wait_valid("w11", 20, p, h, at);
            if (i >= 2) begin
                check("w11_period", 32'(p), 32'd2);
                check("w11_high",   32'(h), 32'd1);
            end
            if (i >= 3) check("w11_interval", 32'(at - prev), 32'd2);
            prev = at;
        end

        // Overflow: one rise, then sig_in held high.
        wave_on   = 1'b0;
        force_lvl = 1'b0;
        meas_en   = 1'b0;
        repeat (5) @(negedge clk);
        meas_en = 1'b1;
        repeat (3) @(negedge clk);
        vc0       = vcnt;
        force_lvl = 1'b1;
        repeat (200) @(negedge clk);
        check("ovf_early", 32'(overflow), 32'd0);
        repeat (80) @(negedge clk);
        check("ovf_set",     32'(overflow),   32'd1);
        check("ovf_novalid", 32'(vcnt),       32'(vc0));
        check("ovf_hold_p",  32'(period_out), 32'd2);
        check("ovf_hold_h",  32'(high_out),   32'd1);

        // Overflow stays set across a later valid measurement.
        force_lvl = 1'b0;
        repeat (5) @(negedge clk);
        hi_len  = 4;
        lo_len  = 6;
        wave_on = 1'b1;
        wait_valid("sticky", 40, p, h, at);
        check("sticky_period", 32'(p), 32'd10);
        check("sticky_high",   32'(h), 32'd4);
        check("sticky_ovf",    32'(overflow), 32'd1);

        // meas_en low for 3 cycles during LOW.
        repeat (5) @(negedge clk);
        meas_en = 1'b0;
        vc0     = vcnt;
        repeat (2) @(negedge clk);
        check("gap_ovf_clr", 32'(overflow), 32'd0);
        @(negedge clk);
        meas_en = 1'b1;
        check("gap_novalid", 32'(vcnt), 32'(vc0));
        prev = at;
        wait_valid("gap_resume", 50, p, h, at);
        check("gap_period",   32'(p), 32'd10);
        check("gap_high",     32'(h), 32'd4);
        check("gap_interval", 32'(at - prev), 32'd30);
        check("gap_ovf",      32'(overflow), 32'd0);

        // One-cycle reset while in HIGH.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_period", 32'(period_out), 32'd0);
        check("mrst_high",   32'(high_out),   32'd0);
        check("mrst_valid",  32'(meas_valid), 32'd0);
        check("mrst_ovf",    32'(overflow),   32'd0);
        reset_n = 1'b1;
        prev    = at;
        wait_valid("mrst_resume", 40, p, h, at);
        check("mrst_interval", 32'(at - prev), 32'd20);
        check("mrst_r_period", 32'(p), 32'd10);
        check("mrst_r_high",   32'(h), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
